// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command-byte handshake between a user and the PS/2 host
// transmitter.
//
// Handshake: a byte transfers on a clk edge where tx_valid && tx_ready are
// both high. The master may raise tx_valid at any time and holds tx_data
// stable while tx_valid is high; tx_ready never depends combinationally on
// tx_valid. tx_done / tx_err are single-cycle completion pulses (never both
// high), busy is high from the accept edge until the block is idle again.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  tx_err,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output tx_err,
        output busy
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter (keyboard commands).
// Inhibits the bus, issues the request-to-send, shifts 8 data bits LSB-first
// plus odd parity and stop on device clock falling edges, then checks the
// device ACK. Both PS/2 lines are open-drain: *_oe = 1 pulls the line low.
// Optional macro PS2_HOST_TX_TIMEOUT_EN adds a watchdog that aborts the frame
// when the device stops clocking; without it the block waits indefinitely.
module ps2_host_tx #(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned INHIBIT_CYC = 12000,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic               clk,
    input  logic               rst,
    ps2_host_tx_if.slave       tx,
    input  logic               ps2_clk_in,
    input  logic               ps2_data_in,
    output logic               ps2_clk_oe,
    output logic               ps2_data_oe,
    output logic [2:0]         dbg_state
);

    if (CLK_HZ < 1 || INHIBIT_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("ps2_host_tx: CLK_HZ, INHIBIT_CYC and TIMEOUT_CYC must be nonzero");
    end

    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_REQ     = 3'd2,
        S_SHIFT   = 3'd3,
        S_ACK     = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bit_q, bit_d;
    logic [8:0]     frame_q, frame_d;
    logic           clk_oe_q, clk_oe_d;
    logic           data_oe_q, data_oe_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           rdy_q;
    logic           clk_s1_q, clk_s2_q, clk_s3_q;
    logic           data_s1_q, data_s2_q;
    logic           fe;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
    logic [WW-1:0]  wd_q, wd_d;
`endif

    // Two-flop synchronizers plus one history flop for clock edge detection;
    // idle bus level is high so they reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_s3_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk_in;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            data_s1_q <= ps2_data_in;
            data_s2_q <= data_s1_q;
        end
    end

    assign fe = clk_s3_q & ~clk_s2_q;

    // State, counters and registered line drivers / completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdy_q     <= 1'b1;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

    // Next-state logic; every return to IDLE releases both lines on that edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        wd_d      = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx.tx_valid && rdy_q) begin
                    frame_d  = {~^tx.tx_data, tx.tx_data};
                    bit_d    = '0;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    // Start bit goes low while the clock is still held, so the
                    // device never sees a released clock with data high.
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                    wd_d      = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                data_oe_d = 1'b1;
                clk_oe_d  = 1'b0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (fe) begin
                    if (bit_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end else begin
                        data_oe_d = ~frame_q[bit_q];
                        bit_d     = bit_q + 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (fe) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    if (!data_s2_q) begin
                        state_d = S_WAIT_HI;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_HI: begin
                if (clk_s2_q && data_s2_q) begin
                    done_d    = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Watchdog over the device-clocked part of the frame; a timeout
        // overrides any completion in the same cycle so done/err stay exclusive.
        if (state_q == S_REQ || state_q == S_SHIFT ||
            state_q == S_ACK || state_q == S_WAIT_HI) begin
            if (fe) begin
                wd_d = '0;
            end else if (wd_q == WD_LAST) begin
                err_d     = 1'b1;
                done_d    = 1'b0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    assign tx.tx_ready = rdy_q && (state_q == S_IDLE);
    assign tx.busy     = (state_q != S_IDLE);
    assign tx.tx_done  = done_q;
    assign tx.tx_err   = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench for ps2_host_tx with a PS/2 device model
// on open-drain lines and a frame-level reference model.
module tb_ps2_host_tx;

    localparam int INH  = 60;
    localparam int TMO  = 400;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_host_tx_if tx_if ();

    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk_in, ps2_data_in;
    logic [2:0] dbg_state;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ      (100000000),
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx          (tx_if.slave),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .dbg_state   (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, unrel_cnt = 0, ready_bad = 0;
    logic prev_err = 1'b0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitor: counts completions and records protocol violations.
    always @(negedge clk) begin
        if (tx_if.tx_done) done_cnt++;
        if (tx_if.tx_err) err_cnt++;
        if (tx_if.tx_done && tx_if.tx_err) both_cnt++;
        if ((tx_if.tx_done || tx_if.tx_err) && (ps2_clk_oe || ps2_data_oe)) unrel_cnt++;
        if (prev_err && !tx_if.tx_ready && !rst) ready_bad++;
        prev_err = tx_if.tx_err;
    end

    // Reference: bits the device reads, data LSB-first, odd parity, stop = 1.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic start_byte(input logic [7:0] b);
        int budget = 200;
        while (!tx_if.tx_ready && budget > 0) begin
            tick(1);
            budget--;
        end
        check("ready_before_send", 32'(tx_if.tx_ready), 32'd1);
        tx_if.tx_data  = b;
        tx_if.tx_valid = 1'b1;
        tick(1);
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'($urandom);
    endtask

    // Device model: waits for request-to-send, generates 11 clocks, reads a
    // bit at each of the first 10 rising edges, optionally ACKs on clock 11.
    task automatic device_frame(input bit ack, input int abort_clk,
                                output logic [9:0] seen, output bit aborted);
        int budget = INH * 4 + 100;
        seen = '0;
        aborted = 1'b0;
        while (!(ps2_clk_in && !ps2_data_in) && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) begin
            check("request_to_send_seen", 32'd0, 32'd1);
            return;
        end
        tick(HALF);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && ack) begin
                dev_data_low = 1'b1;
                tick(4);
            end
            dev_clk_low = 1'b1;
            tick(HALF);
            if (i == abort_clk) begin
                aborted = 1'b1;
                return;
            end
            if (i <= 10) seen[i-1] = ps2_data_in;
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            tick(HALF);
        end
    endtask

    task automatic send_and_check(input logic [7:0] b, input bit ack, input bit measure);
        int d0 = done_cnt;
        int e0 = err_cnt;
        int cnt = 0;
        int budget;
        logic [9:0] seen;
        logic [9:0] exp;
        bit ab;
        exp_q.push_back(ref_frame(b));
        start_byte(b);
        if (measure) begin
            // Requests while busy, with changing data, must be ignored.
            budget = INH * 4;
            tx_if.tx_valid = 1'b1;
            while (!ps2_data_oe && budget > 0) begin
                if (ps2_clk_oe) cnt++;
                tx_if.tx_data = 8'($urandom);
                tick(1);
                budget--;
            end
            check("inhibit_len", 32'(cnt), 32'(INH));
            check("clk_held_at_start_bit", 32'(ps2_clk_oe), 32'd1);
            tx_if.tx_valid = 1'b0;
        end
        device_frame(ack, 0, seen, ab);
        exp = exp_q.pop_front();
        check($sformatf("frame_%02h", b), 32'(seen), 32'(exp));
        budget = 100;
        while (tx_if.busy && budget > 0) begin
            tick(1);
            budget--;
        end
        check($sformatf("idle_after_%02h", b), 32'(tx_if.busy), 32'd0);
        check($sformatf("done_%02h", b), 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
        check($sformatf("err_%02h", b), 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
        check($sformatf("lines_free_%02h", b), {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [9:0] seen;
        bit ab;
        int d0, e0, k, budget;
        rst = 1'b1;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        tick(3);
        check("rst_ready", 32'(tx_if.tx_ready), 32'd0);
        check("rst_busy", 32'(tx_if.busy), 32'd0);
        check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("rst_pulses", {30'd0, tx_if.tx_done, tx_if.tx_err}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_before_first_edge", 32'(tx_if.tx_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_first_edge", 32'(tx_if.tx_ready), 32'd1);
        tick(2);

        send_and_check(8'hED, 1'b1, 1'b0);
        send_and_check(8'h00, 1'b1, 1'b0);
        send_and_check(8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_and_check(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        send_and_check(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        send_and_check(8'hF4, 1'b1, 1'b1);

        // Reset while the host is presenting data bit 4.
        d0 = done_cnt;
        e0 = err_cnt;
        start_byte(8'h5A);
        device_frame(1'b1, 5, seen, ab);
        check("abort_reached", 32'(ab), 32'd1);
        check("bit4_driven", 32'(ps2_data_in), 32'(~8'h5A >> 4 & 1 ^ 1));
        rst = 1'b1;
        #1;
        check("midrst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("midrst_busy_ready", {30'd0, tx_if.busy, tx_if.tx_ready}, 32'd0);
        tick(2);
        dev_clk_low = 1'b0;
        rst = 1'b0;
        tick(3);
        check("midrst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        send_and_check(8'hFF, 1'b1, 1'b0);

        // Device never clocks after the request-to-send.
        e0 = err_cnt;
        start_byte(8'h3C);
        budget = INH * 4;
        while (!ps2_data_oe && budget > 0) begin
            tick(1);
            budget--;
        end
        k = 0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        while (!tx_if.tx_err && k < TMO * 2) begin
            k++;
            tick(1);
        end
        check("timeout_cycles", 32'(k), 32'(TMO));
        tick(1);
        check("timeout_idle", 32'(tx_if.busy), 32'd0);
        check("timeout_err_once", 32'(err_cnt - e0), 32'd1);
`else
        tick(TMO + 50);
        check("stall_busy", 32'(tx_if.busy), 32'd1);
        check("stall_no_err", 32'(err_cnt - e0), 32'd0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
`endif
        send_and_check(8'($urandom_range(0, 255)), 1'b1, 1'b0);

        check("done_err_overlap", 32'(both_cnt), 32'd0);
        check("lines_released_on_pulse", 32'(unrel_cnt), 32'd0);
        check("ready_after_err", 32'(ready_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
- REQ-001: Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
- REQ-002: Parameter INHIBIT_CYC, default 12000, clk cycles PS2 clock is held low to request send (120 us).
- REQ-003: Parameter TIMEOUT_CYC, default 200000, clk cycles without a device clock falling edge before abort (2 ms).
- REQ-004: clk  input  1  system clock; all logic on posedge.
- REQ-005: rst  input  1  reset, asynchronous, active-high.
- REQ-006: tx_data  input  8  command byte to the keyboard.
- REQ-007: tx_valid  input  1  request; byte accepted when tx_valid && tx_ready.
- REQ-008: tx_ready  output  1  high only in IDLE.
- REQ-009: tx_done  output  1  one-cycle pulse, byte acknowledged by device.
- REQ-010: tx_err  output  1  one-cycle pulse, missing ACK or timeout.
- REQ-011: busy  output  1  high in every state except IDLE.
- REQ-012: ps2_clk_in  input  1  raw PS2_CLK pin level.
- REQ-013: ps2_data_in  input  1  raw PS2_DATA pin level.
- REQ-014: ps2_clk_oe  output  1  1 = drive PS2_CLK low, 0 = release (open-drain, tristated at top).
- REQ-015: ps2_data_oe  output  1  1 = drive PS2_DATA low, 0 = release.

Function
- REQ-016: ps2_clk_in and ps2_data_in SHALL pass a 2-flop synchronizer; a falling edge (fe) is synchronized clock 1 -> 0 between consecutive cycles.
- REQ-017: States SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_HI.
- REQ-018: IDLE: on accept, latch tx_data, compute odd parity (~^tx_data), set bit counter 0, clk_oe=1, go INHIBIT.
- REQ-019: INHIBIT: hold clk_oe=1 for exactly INHIBIT_CYC cycles; on the last cycle set data_oe=1 (start bit) and go REQ.
- REQ-020: REQ: hold data_oe=1, clk_oe=0 for 1 cycle, then go SHIFT.
- REQ-021: SHIFT: on each fe, drive frame bit n (n=0..7 data LSB-first, n=8 parity) as data_oe = ~bit, increment n; on fe with n=9 set data_oe=0 (stop bit) and go ACK.
- REQ-022: ACK: on next fe sample synchronized data; 0 -> go WAIT_HI; 1 -> pulse tx_err, go IDLE.
- REQ-023: WAIT_HI: when synchronized clock and data both high, pulse tx_done, go IDLE.
- REQ-024: tx_valid while busy SHALL be ignored; tx_data changes after accept SHALL not affect the frame.
- REQ-025: On every transition to IDLE, clk_oe=0 and data_oe=0 in that same cycle; tx_done and tx_err never both high.
- REQ-026: clk_oe and data_oe SHALL be registered outputs, glitch-free.

Reset
- REQ-027: rst high SHALL immediately force state IDLE, clk_oe=0, data_oe=0, tx_done=0, tx_err=0, busy=0, tx_ready=0; tx_ready=1 from first clk edge after rst falls.
- REQ-028: rst mid-frame SHALL abort without a tx_done or tx_err pulse; synchronizers reset to 1.

Configuration
- REQ-029: Macro PS2_HOST_TX_TIMEOUT_EN defined: watchdog counter cleared on entering REQ and on every fe; reaching TIMEOUT_CYC in REQ/SHIFT/ACK/WAIT_HI pulses tx_err, releases both lines, goes IDLE.
- REQ-030: Macro undefined: no watchdog logic; SHIFT/ACK/WAIT_HI wait indefinitely.

Verification
- REQ-031: Send 0xED, device model clocks at 12.5 kHz, pulls data low on bit 11 -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1 seen at device rising edges; one tx_done pulse.
- REQ-032: Send 0x00 -> parity 1; send 0x01 -> parity 0; both tx_done.
- REQ-033: Device model omits ACK (data stays high) -> tx_err one pulse, lines released, tx_ready=1 next cycle.
- REQ-034: Accept 0xF4, measure clk_oe -> low for exactly 12000 cycles before data_oe asserts.
- REQ-035: Assert rst during bit 4 -> both oe=0 same cycle, no done/err pulse; new 0xFF then completes.
- REQ-036: With PS2_HOST_TX_TIMEOUT_EN, device never clocks -> tx_err 200000 cycles after REQ entry; without macro, busy stays 1.
